rgst_shift_reg: RTL and testbench

//  Parameterised loadable bidirectional shift register for the ALU datapath (A/Q/M style operand regs).
//  Per-bit structure: 4:1 mux (keep / load / right / left) feeding a D flip-flop.

---
 rtl/rgst_pkg.sv | 12 +
 rtl/dff.sv | 18 +
 rtl/mux_4_to_1.sv | 23 ++
 rtl/rgst_shift_reg.sv | 93 +++++++++
 tb/tb_rgst_shift_reg.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rgst_pkg.sv
// Shared constants for the rgst shift register datapath: per-bit mux select
// encoding and the minimum supported register width.
package rgst_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LEFT  = 2'b11;

    localparam int MIN_WIDTH = 3;

endpackage

// File: rtl/dff.sv
// Single-bit D flip-flop with synchronous active-high reset and load enable.
module dff (
    input  logic clk,
    input  logic reset,
    input  logic load_enable,
    input  logic data_in,
    output logic data_out
);

    // Capture data_in only when enabled; reset wins over the enable
    always_ff @(posedge clk) begin
        if (reset)
            data_out <= 1'b0;
        else if (load_enable)
            data_out <= data_in;
    end

endmodule

// File: rtl/mux_4_to_1.sv
// One-bit 4:1 mux feeding each register bit.
// data_in ordering is {left, right, load, keep}, indexed by the rgst_pkg select codes.
module mux_4_to_1
    import rgst_pkg::*;
(
    input  logic [3:0] data_in,
    input  logic [1:0] select,
    output logic       data_out
);

    // Route the chosen source for this bit
    always_comb begin
        data_out = data_in[0];
        case (select)
            SEL_HOLD:  data_out = data_in[0];
            SEL_LOAD:  data_out = data_in[1];
            SEL_RIGHT: data_out = data_in[2];
            SEL_LEFT:  data_out = data_in[3];
            default:   data_out = data_in[0];
        endcase
    end

endmodule

// File: rtl/rgst_shift_reg.sv
// Loadable bidirectional shift register for the ALU operand registers.
// Priority load > left > right > hold. Left shift can optionally write the
// inserted bit into both bit 0 and bit 1 (jump_LSb) for radix-4 style steps.
// Right shift takes the MSB from right_shift_value, so an arithmetic shift is
// obtained by feeding back data_out[width-1].
// Optional build macro: RGST_SHIFT_OUT_EN adds shift_out_msb / shift_out_lsb,
// which capture the bit shifted out by the last left / right shift.
// width must be at least rgst_pkg::MIN_WIDTH, since bits 0, 1 and width-1
// each need their own wiring.
module rgst_shift_reg
    import rgst_pkg::*;
#(
    parameter int width = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_enable,
    input  logic [width-1:0] data_in,
    input  logic             left_shift_enable,
    input  logic             left_shift_value,
    input  logic             right_shift_enable,
    input  logic             right_shift_value,
    input  logic             jump_LSb,
`ifdef RGST_SHIFT_OUT_EN
    output logic             shift_out_msb,
    output logic             shift_out_lsb,
`endif
    output logic [width-1:0] data_out
);

    logic [1:0] sel;
    logic       ff_enable;

    // Shared select and enable; hold never clocks the flops
    always_comb begin
        sel[1]    = ~load_enable & (left_shift_enable | right_shift_enable);
        sel[0]    = load_enable | left_shift_enable;
        ff_enable = load_enable | left_shift_enable | right_shift_enable;
    end

    genvar i;
    generate
        for (i = 0; i < width; i++) begin : g_bit
            logic left_src;
            logic right_src;
            logic mux_out;

            if (i == 0) begin : g_lsb
                assign left_src = left_shift_value;
            end else if (i == 1) begin : g_bit1
                assign left_src = jump_LSb ? left_shift_value : data_out[0];
            end else begin : g_mid_left
                assign left_src = data_out[i-1];
            end

            if (i == width - 1) begin : g_msb
                assign right_src = right_shift_value;
            end else begin : g_mid_right
                assign right_src = data_out[i+1];
            end

            mux_4_to_1 u_mux (
                .data_in  ({left_src, right_src, data_in[i], data_out[i]}),
                .select   (sel),
                .data_out (mux_out)
            );

            dff u_dff (
                .clk         (clk),
                .reset       (reset),
                .load_enable (ff_enable),
                .data_in     (mux_out),
                .data_out    (data_out[i])
            );
        end
    endgenerate

`ifdef RGST_SHIFT_OUT_EN
    // Remember the bit that fell off each end on the last shift in that direction
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_out_msb <= 1'b0;
            shift_out_lsb <= 1'b0;
        end else begin
            if (sel == SEL_LEFT)
                shift_out_msb <= data_out[width-1];
            if (sel == SEL_RIGHT)
                shift_out_lsb <= data_out[0];
        end
    end
`endif

endmodule

// File: tb/tb_rgst_shift_reg.sv
// Self-checking bench for rgst_shift_reg at width 8: directed cases followed by
// randomised operations, with expected register values queued at drive time.
module tb_rgst_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_enable;
    logic [W-1:0] data_in;
    logic         left_shift_enable;
    logic         left_shift_value;
    logic         right_shift_enable;
    logic         right_shift_value;
    logic         jump_LSb;
    logic [W-1:0] data_out;
`ifdef RGST_SHIFT_OUT_EN
    logic         shift_out_msb;
    logic         shift_out_lsb;
    logic         m_msb = 1'b0;
    logic         m_lsb = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model = '0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    rgst_shift_reg #(.width(W)) dut (
        .clk                (clk),
        .reset              (reset),
        .load_enable        (load_enable),
        .data_in            (data_in),
        .left_shift_enable  (left_shift_enable),
        .left_shift_value   (left_shift_value),
        .right_shift_enable (right_shift_enable),
        .right_shift_value  (right_shift_value),
        .jump_LSb           (jump_LSb),
`ifdef RGST_SHIFT_OUT_EN
        .shift_out_msb      (shift_out_msb),
        .shift_out_lsb      (shift_out_lsb),
`endif
        .data_out           (data_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] next_val(input logic [W-1:0] cur, input logic rst, ld,
                                              input logic [W-1:0] din, input logic ls, lsv,
                                              input logic rs, rsv, j);
        if (rst)      return '0;
        if (ld)       return din;
        if (ls)       return j ? {cur[W-2:1], lsv, lsv} : {cur[W-2:0], lsv};
        if (rs)       return {rsv, cur[W-1:1]};
        return cur;
    endfunction

    // One clock: drive at negedge, queue expectation, compare #1 after posedge.
    // use_exp=1 queues the supplied constant instead of the model prediction.
    task automatic step(input string tag, input logic rst, ld, input logic [W-1:0] din,
                        input logic ls, lsv, rs, rsv, j,
                        input logic use_exp, input logic [W-1:0] exp_v);
        logic [W-1:0] nv;
        @(negedge clk);
        reset              = rst;
        load_enable        = ld;
        data_in            = din;
        left_shift_enable  = ls;
        left_shift_value   = lsv;
        right_shift_enable = rs;
        right_shift_value  = rsv;
        jump_LSb           = j;
        nv = use_exp ? exp_v : next_val(model, rst, ld, din, ls, lsv, rs, rsv, j);
        exp_q.push_back(nv);
`ifdef RGST_SHIFT_OUT_EN
        if (rst) begin
            m_msb = 1'b0;
            m_lsb = 1'b0;
        end else if (!ld && ls) begin
            m_msb = model[W-1];
        end else if (!ld && rs) begin
            m_lsb = model[0];
        end
`endif
        model = nv;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            check(tag, {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
`ifdef RGST_SHIFT_OUT_EN
        check({tag, "_msb"}, {31'd0, shift_out_msb}, {31'd0, m_msb});
        check({tag, "_lsb"}, {31'd0, shift_out_lsb}, {31'd0, m_lsb});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; load_enable = 1'b0; data_in = '0;
        left_shift_enable = 1'b0; left_shift_value = 1'b0;
        right_shift_enable = 1'b0; right_shift_value = 1'b0; jump_LSb = 1'b0;

        //     tag          rst ld  din    ls lsv rs rsv j  use exp
        step("reset",      1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00);
        step("load_b2",    0, 1, 8'hB2, 0, 0, 0, 0, 0, 1, 8'hB2);
        step("idle_hold",  0, 0, 8'hFF, 0, 0, 0, 0, 0, 1, 8'hB2);
        step("left_v0",    0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h64);
        step("left_v1",    0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 8'hC9);
        step("right_v1",   0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 8'hE4);
        step("right_v0",   0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h72);
        step("left_jump",  0, 0, 8'h00, 1, 1, 0, 0, 1, 1, 8'hE7);
        step("load_left",  0, 1, 8'hA5, 1, 1, 0, 0, 0, 1, 8'hA5);
        step("load_81",    0, 1, 8'h81, 0, 0, 0, 0, 0, 1, 8'h81);
        step("ls_rs_both", 0, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'h02);
        step("right_jmp",  0, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'h81);
        step("load_rshift",0, 1, 8'h3C, 0, 0, 1, 1, 0, 1, 8'h3C);
        step("rst_load",   1, 1, 8'hFF, 0, 0, 0, 0, 0, 1, 8'h00);
        step("load_f0",    0, 1, 8'hF0, 0, 0, 0, 0, 0, 1, 8'hF0);
        step("left_mid",   0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 8'hE1);
        step("rst_shift",  1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h00);
        step("left_after", 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h01);
        step("right_msb",  0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 8'h80);

`ifdef RGST_SHIFT_OUT_EN
        step("so_load_81", 0, 1, 8'h81, 0, 0, 0, 0, 0, 1, 8'h81);
        step("so_left",    0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h02);
        check("so_msb_set", {31'd0, shift_out_msb}, 32'd1);
        step("so_right",   0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h01);
        check("so_lsb_zero", {31'd0, shift_out_lsb}, 32'd0);
        check("so_msb_kept", {31'd0, shift_out_msb}, 32'd1);
`endif

        for (int k = 0; k < 60; k++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 4) == 0),
                 W'($urandom),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
